// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared FSM state and transfer-size encodings for the data SRAM bridge
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } bridge_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/dsram_size_enc.sv
// rtl/dsram_size_enc.sv - byte-enable to {size, addr_lo} encoder, used only when DSRAM_BRIDGE_SIZE_ENC_EN is defined
module dsram_size_enc
  import cpu_bus_pkg::*;
(
  input  logic [3:0] i_wen,
  output logic [1:0] o_size,
  output logic [1:0] o_addr_lo
);

  // Single lanes become byte accesses, aligned pairs become halves, anything else is a full word
  always_comb begin
    o_size    = SIZE_WORD;
    o_addr_lo = 2'b00;
    case (i_wen)
      4'b0001: begin o_size = SIZE_BYTE; o_addr_lo = 2'd0; end
      4'b0010: begin o_size = SIZE_BYTE; o_addr_lo = 2'd1; end
      4'b0100: begin o_size = SIZE_BYTE; o_addr_lo = 2'd2; end
      4'b1000: begin o_size = SIZE_BYTE; o_addr_lo = 2'd3; end
      4'b0011: begin o_size = SIZE_HALF; o_addr_lo = 2'd0; end
      4'b1100: begin o_size = SIZE_HALF; o_addr_lo = 2'd2; end
      default: ;
    endcase
  end

endmodule

// File: rtl/dsram_like_bridge.sv
// rtl/dsram_like_bridge.sv - single-cycle data SRAM port to req/addr_ok/data_ok bridge; DSRAM_BRIDGE_SIZE_ENC_EN enables write size encoding
module dsram_like_bridge
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              cpu_stall_in,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  bridge_state_t     r_state;
  logic              r_req;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic [DATA_W-1:0] r_rdata;

  logic              w_wr;
  logic [1:0]        w_size;
  logic [1:0]        w_addr_lo;
  logic              w_unused_addr_lo;

  assign w_wr = |cpu_wen;

`ifdef DSRAM_BRIDGE_SIZE_ENC_EN
  logic [1:0] w_enc_size;
  logic [1:0] w_enc_addr_lo;

  dsram_size_enc u_size_enc (
    .i_wen     (cpu_wen),
    .o_size    (w_enc_size),
    .o_addr_lo (w_enc_addr_lo)
  );

  // Reads stay word-sized and word-aligned; only writes are narrowed
  assign w_size    = w_wr ? w_enc_size    : SIZE_WORD;
  assign w_addr_lo = w_wr ? w_enc_addr_lo : 2'b00;
`else
  assign w_size    = SIZE_WORD;
  assign w_addr_lo = 2'b00;
`endif

  // The low address bits are always replaced by the lane encoding above
  assign w_unused_addr_lo = ^cpu_addr[1:0];

  // Access sequencer: capture once in IDLE, hold request until addr_ok, wait for data_ok, then park in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_wr    <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= 4'b0000;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_en) begin
            r_addr  <= {cpu_addr[ADDR_W-1:2], w_addr_lo};
            r_wdata <= cpu_wdata;
            r_wstrb <= cpu_wen;
            r_wr    <= w_wr;
            r_size  <= w_size;
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          // data_ok before the address is accepted is not a valid response and is ignored
          if (mem_addr_ok) begin
            r_req <= 1'b0;
            if (mem_data_ok) begin
              if (!r_wr) r_rdata <= mem_rdata;
              r_state <= DONE;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_data_ok) begin
            if (!r_wr) r_rdata <= mem_rdata;
            r_state <= DONE;
          end
        end
        DONE: begin
          // A frozen pipeline keeps cpu_en high here; waiting in DONE keeps it from re-issuing
          if (!cpu_stall_in) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall     = !rst && (((r_state == IDLE) && cpu_en) || (r_state == REQ) || (r_state == WAIT));
  assign mem_req   = r_req;
  assign mem_wr    = r_wr;
  assign mem_size  = r_size;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;
  assign cpu_rdata = r_rdata;

endmodule

// File: tb/tb_dsram_like_bridge.sv
// tb/tb_dsram_like_bridge.sv - directed self-checking bench for dsram_like_bridge
module tb_dsram_like_bridge;
  import cpu_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_en = 1'b0;
  logic [3:0]  cpu_wen = 4'b0000;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall_in = 1'b0;
  logic        stall;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [31:0] mem_model [logic [31:0]];

  int   cyc = 0;
  int   req_starts = 0;
  int   last_issue = -100;
  logic prev_req = 1'b0;

  dsram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall_in(cpu_stall_in), .stall(stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Count request issues (rising edges of mem_req) and remember when the latest one happened
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_req <= mem_req;
    if (mem_req && !prev_req) begin
      req_starts <= req_starts + 1;
      last_issue <= cyc;
    end
  end

  // Drives one CPU access and plays the memory side with given addr_ok / data_ok latencies.
  // Returns at the negedge of the DONE cycle; cpu_en drops there unless hold is set.
  task automatic run_access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                            input int alat, input int dlat, input bit hold,
                            output int stalls, output int req_cycles, output bit addr_stable,
                            output bit timed_out, output logic [31:0] q_addr, output logic [1:0] q_size,
                            output logic q_wr, output logic [3:0] q_wstrb);
    int rc = 0;
    int ak = -1;
    bit fin = 0;
    logic [31:0] q_wdata = 32'h0;
    stalls = 0; req_cycles = 0; addr_stable = 1; timed_out = 1;
    q_addr = 32'h0; q_size = 2'b00; q_wr = 1'b0; q_wstrb = 4'b0000;
    for (int k = 0; k < 60 && !fin; k++) begin
      @(negedge clk);
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = 32'hBAD0_BAD0;
      if (k > 0 && !stall) begin
        timed_out = 0;
        fin = 1;
        if (hold) cpu_stall_in = 1'b1;
        else begin cpu_en = 1'b0; cpu_wen = 4'b0000; end
      end else begin
        if (k == 0) begin cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata; end
        if (mem_req) begin
          rc++;
          if (rc == 1) begin
            q_addr = mem_addr; q_size = mem_size; q_wr = mem_wr; q_wstrb = mem_wstrb; q_wdata = mem_wdata;
          end else if (mem_addr !== q_addr) addr_stable = 0;
          if (rc == alat + 1) begin mem_addr_ok = 1'b1; ak = k; end
        end
        if (ak >= 0 && k == ak + dlat) begin
          mem_data_ok = 1'b1;
          if (q_wr) mem_model[q_addr] = q_wdata;
          else mem_rdata = mem_model.exists(q_addr) ? mem_model[q_addr] : 32'h0;
        end
        #1;
        if (stall) stalls++;
      end
    end
    req_cycles = rc;
  endtask

  task automatic test_reset();
    cpu_en = 1'b1;
    @(negedge clk);
    vec_cnt++; if (mem_req !== 1'b0) begin err_cnt++; $display("FAIL reset.mem_req got %b exp 0", mem_req); end
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL reset.stall got %b exp 0", stall); end
    vec_cnt++; if (cpu_rdata !== 32'h0) begin err_cnt++; $display("FAIL reset.cpu_rdata got %h exp 0", cpu_rdata); end
    vec_cnt++; if ({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !== 71'h0) begin err_cnt++; $display("FAIL reset.mem_fields got wr=%b size=%0d strb=%b addr=%h exp all 0", mem_wr, mem_size, mem_wstrb, mem_addr); end
    cpu_en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_fast_read();
    int st, rc; bit stab, to; logic [31:0] qa; logic [1:0] qs; logic qw; logic [3:0] qb;
    mem_model[32'h0000_1000] = 32'hDEAD_BEEF;
    run_access(4'b0000, 32'h0000_1000, 32'h0, 0, 0, 0, st, rc, stab, to, qa, qs, qw, qb);
    vec_cnt++; if (to !== 1'b0) begin err_cnt++; $display("FAIL fast_read.timeout got %b exp 0", to); end
    vec_cnt++; if (st !== 2) begin err_cnt++; $display("FAIL fast_read.stalls got %0d exp 2", st); end
    vec_cnt++; if (cpu_rdata !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL fast_read.rdata got %h exp deadbeef", cpu_rdata); end
    vec_cnt++; if ({qw, qs, qb} !== {1'b0, SIZE_WORD, 4'b0000}) begin err_cnt++; $display("FAIL fast_read.fields got wr=%b size=%0d strb=%b exp wr=0 size=2 strb=0000", qw, qs, qb); end
    vec_cnt++; if (qa !== 32'h0000_1000) begin err_cnt++; $display("FAIL fast_read.addr got %h exp 00001000", qa); end
  endtask

  task automatic test_write_lane();
    int st, rc; bit stab, to; logic [31:0] qa; logic [1:0] qs; logic qw; logic [3:0] qb;
    logic [31:0] exp_addr; logic [1:0] exp_size;
`ifdef DSRAM_BRIDGE_SIZE_ENC_EN
    exp_addr = 32'h0000_2002; exp_size = SIZE_BYTE;
`else
    exp_addr = 32'h0000_2000; exp_size = SIZE_WORD;
`endif
    run_access(4'b0100, 32'h0000_2003, 32'h00AB_0000, 0, 1, 0, st, rc, stab, to, qa, qs, qw, qb);
    vec_cnt++; if (to !== 1'b0) begin err_cnt++; $display("FAIL write_lane.timeout got %b exp 0", to); end
    vec_cnt++; if (qw !== 1'b1) begin err_cnt++; $display("FAIL write_lane.wr got %b exp 1", qw); end
    vec_cnt++; if (qb !== 4'b0100) begin err_cnt++; $display("FAIL write_lane.wstrb got %b exp 0100", qb); end
    vec_cnt++; if (qs !== exp_size) begin err_cnt++; $display("FAIL write_lane.size got %0d exp %0d", qs, exp_size); end
    vec_cnt++; if (qa !== exp_addr) begin err_cnt++; $display("FAIL write_lane.addr got %h exp %h", qa, exp_addr); end
    vec_cnt++; if (st !== 3) begin err_cnt++; $display("FAIL write_lane.stalls got %0d exp 3", st); end
    vec_cnt++; if (cpu_rdata !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL write_lane.rdata_kept got %h exp deadbeef", cpu_rdata); end
  endtask

  task automatic test_delayed_read();
    int st, rc; bit stab, to; logic [31:0] qa; logic [1:0] qs; logic qw; logic [3:0] qb;
    mem_model[32'h0000_3000] = 32'h1234_5678;
    run_access(4'b0000, 32'h0000_3000, 32'h0, 3, 4, 0, st, rc, stab, to, qa, qs, qw, qb);
    vec_cnt++; if (to !== 1'b0) begin err_cnt++; $display("FAIL delayed.timeout got %b exp 0", to); end
    vec_cnt++; if (st !== 9) begin err_cnt++; $display("FAIL delayed.stalls got %0d exp 9", st); end
    vec_cnt++; if (rc !== 4) begin err_cnt++; $display("FAIL delayed.req_cycles got %0d exp 4", rc); end
    vec_cnt++; if (stab !== 1'b1) begin err_cnt++; $display("FAIL delayed.addr_stable got %b exp 1", stab); end
    vec_cnt++; if (cpu_rdata !== 32'h1234_5678) begin err_cnt++; $display("FAIL delayed.rdata got %h exp 12345678", cpu_rdata); end
  endtask

  task automatic test_done_hold();
    int st, rc, s0; bit stab, to; logic [31:0] qa; logic [1:0] qs; logic qw; logic [3:0] qb;
    mem_model[32'h0000_4000] = 32'hCAFE_F00D;
    mem_model[32'h0000_4004] = 32'h0102_0304;
    s0 = req_starts;
    run_access(4'b0000, 32'h0000_4000, 32'h0, 0, 0, 1, st, rc, stab, to, qa, qs, qw, qb);
    vec_cnt++; if (to !== 1'b0) begin err_cnt++; $display("FAIL hold.timeout got %b exp 0", to); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec_cnt++; if ({stall, mem_req} !== 2'b00) begin err_cnt++; $display("FAIL hold.stall_req[%0d] got stall=%b req=%b exp 0 0", i, stall, mem_req); end
      vec_cnt++; if (cpu_rdata !== 32'hCAFE_F00D) begin err_cnt++; $display("FAIL hold.rdata[%0d] got %h exp cafef00d", i, cpu_rdata); end
      if (i == 4) begin cpu_stall_in = 1'b0; cpu_en = 1'b0; end
    end
    vec_cnt++; if (req_starts !== s0 + 1) begin err_cnt++; $display("FAIL hold.issues got %0d exp %0d", req_starts - s0, 1); end
    run_access(4'b0000, 32'h0000_4004, 32'h0, 0, 0, 0, st, rc, stab, to, qa, qs, qw, qb);
    vec_cnt++; if ({to, st} !== {1'b0, 32'd2}) begin err_cnt++; $display("FAIL hold.next_stalls got %0d (timeout %b) exp 2", st, to); end
    vec_cnt++; if (cpu_rdata !== 32'h0102_0304) begin err_cnt++; $display("FAIL hold.next_rdata got %h exp 01020304", cpu_rdata); end
  endtask

  task automatic test_reset_mid();
    int st, rc; bit stab, to; logic [31:0] qa; logic [1:0] qs; logic qw; logic [3:0] qb;
    mem_model[32'h0000_5000] = 32'h55AA_55AA;
    @(negedge clk);
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_5000;
    @(negedge clk);
    vec_cnt++; if (mem_req !== 1'b1) begin err_cnt++; $display("FAIL rst_mid.req got %b exp 1", mem_req); end
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    vec_cnt++; if ({mem_req, stall} !== 2'b01) begin err_cnt++; $display("FAIL rst_mid.wait got req=%b stall=%b exp 0 1", mem_req, stall); end
    #2 rst = 1'b1;
    #1;
    vec_cnt++; if ({mem_req, stall} !== 2'b00) begin err_cnt++; $display("FAIL rst_mid.async got req=%b stall=%b exp 0 0", mem_req, stall); end
    vec_cnt++; if (cpu_rdata !== 32'h0) begin err_cnt++; $display("FAIL rst_mid.rdata got %h exp 0", cpu_rdata); end
    vec_cnt++; if (mem_addr !== 32'h0) begin err_cnt++; $display("FAIL rst_mid.addr got %h exp 0", mem_addr); end
    @(negedge clk);
    rst = 1'b0; cpu_en = 1'b0;
    run_access(4'b0000, 32'h0000_5000, 32'h0, 0, 0, 0, st, rc, stab, to, qa, qs, qw, qb);
    vec_cnt++; if ({to, st} !== {1'b0, 32'd2}) begin err_cnt++; $display("FAIL rst_mid.after_stalls got %0d (timeout %b) exp 2", st, to); end
    vec_cnt++; if (cpu_rdata !== 32'h55AA_55AA) begin err_cnt++; $display("FAIL rst_mid.after_rdata got %h exp 55aa55aa", cpu_rdata); end
  endtask

  task automatic test_early_data_ok();
    @(negedge clk);
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_6000;
    @(negedge clk);
    mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    vec_cnt++; if ({mem_req, stall} !== 2'b11) begin err_cnt++; $display("FAIL early.req_held got req=%b stall=%b exp 1 1", mem_req, stall); end
    vec_cnt++; if (cpu_rdata !== 32'h55AA_55AA) begin err_cnt++; $display("FAIL early.rdata_kept got %h exp 55aa55aa", cpu_rdata); end
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h600D_D00D;
    @(negedge clk);
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'hBAD0_BAD0;
    vec_cnt++; if ({stall, cpu_rdata} !== {1'b0, 32'h600D_D00D}) begin err_cnt++; $display("FAIL early.done got stall=%b rdata=%h exp 0 600dd00d", stall, cpu_rdata); end
    cpu_en = 1'b0;
    @(negedge clk);
    mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_data_ok = 1'b0;
    vec_cnt++; if ({mem_req, stall, cpu_rdata} !== {2'b00, 32'h600D_D00D}) begin err_cnt++; $display("FAIL early.idle_dok got req=%b stall=%b rdata=%h exp 0 0 600dd00d", mem_req, stall, cpu_rdata); end
  endtask

  task automatic test_back_to_back();
    int st_w, st_r, rc, s0, i0; bit stab, to_w, to_r; logic [31:0] qa; logic [1:0] qs; logic qw; logic [3:0] qb;
    s0 = req_starts;
    run_access(4'b1111, 32'h0000_0010, 32'h1122_3344, 0, 0, 0, st_w, rc, stab, to_w, qa, qs, qw, qb);
    i0 = last_issue;
    vec_cnt++; if ({qw, qb, qa} !== {1'b1, 4'b1111, 32'h0000_0010}) begin err_cnt++; $display("FAIL b2b.write_fields got wr=%b strb=%b addr=%h exp 1 1111 00000010", qw, qb, qa); end
    run_access(4'b0000, 32'h0000_0010, 32'h0, 0, 0, 0, st_r, rc, stab, to_r, qa, qs, qw, qb);
    vec_cnt++; if ({to_w, to_r, st_w, st_r} !== {2'b00, 32'd2, 32'd2}) begin err_cnt++; $display("FAIL b2b.stalls got w=%0d r=%0d (timeouts %b%b) exp 2 2", st_w, st_r, to_w, to_r); end
    vec_cnt++; if (cpu_rdata !== 32'h1122_3344) begin err_cnt++; $display("FAIL b2b.rdata got %h exp 11223344", cpu_rdata); end
    vec_cnt++; if (req_starts !== s0 + 2) begin err_cnt++; $display("FAIL b2b.issues got %0d exp 2", req_starts - s0); end
    vec_cnt++; if (last_issue - i0 !== 3) begin err_cnt++; $display("FAIL b2b.spacing got %0d exp 3", last_issue - i0); end
  endtask

  initial begin
    test_reset();
    test_fast_read();
    test_write_lane();
    test_delayed_read();
    test_done_hold();
    test_reset_mid();
    test_early_data_ok();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
